// File: rtl/branch_pc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : branch_pc_ctrl                                                  |
// | Purpose  : Fetch PC sequencer with branch/jump redirect and pending-target |
// |            handling. Optional macro BRANCH_PC_MISALIGN_TRAP_EN turns       |
// |            misaligned redirect targets into a trap pulse.                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module branch_pc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic        is_branch,
   input  logic        is_jump,
   input  logic        branch_taken,
   input  logic [31:0] target_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        misalign_trap
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic [31:0] r_pend_tgt;
   logic        r_pend;
   logic        r_trap;
   logic        r_imem_req;
   logic        r_instr_valid;

   logic        w_redir_cond;
   logic        w_take;
   logic        w_trap;
   logic [31:0] w_tgt;

   // is_jump dominates because it alone satisfies the OR regardless of the branch terms
   assign w_redir_cond = redirect_valid & (is_jump | (is_branch & branch_taken));

`ifdef BRANCH_PC_MISALIGN_TRAP_EN
   assign w_tgt  = target_addr;
   assign w_take = w_redir_cond & (target_addr[1:0] == 2'b00);
   assign w_trap = w_redir_cond & (target_addr[1:0] != 2'b00) & (r_state != S_IDLE);
`else
   logic w_unused_tgt_lsb;
   assign w_unused_tgt_lsb = ^target_addr[1:0];
   assign w_tgt  = {target_addr[31:2], 2'b00};
   assign w_take = w_redir_cond;
   assign w_trap = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_instr       <= 32'h0;
         r_instr_pc    <= 32'h0;
         r_pend_tgt    <= 32'h0;
         r_pend        <= 1'b0;
         r_trap        <= 1'b0;
         r_imem_req    <= 1'b0;
         r_instr_valid <= 1'b0;
      end else begin
         r_trap <= w_trap;
         case (r_state)
            S_IDLE: begin
               r_state    <= S_REQ;
               r_pc       <= RESET_PC;
               r_imem_req <= 1'b1;
            end
            S_REQ: begin
               if (imem_ack) begin
                  // Any redirect seen during this request turns the returned word into garbage
                  if (w_take) begin
                     r_pc   <= w_tgt;
                     r_pend <= 1'b0;
                  end else if (r_pend) begin
                     r_pc   <= r_pend_tgt;
                     r_pend <= 1'b0;
                  end else begin
                     r_instr       <= imem_rdata;
                     r_instr_pc    <= r_pc;
                     r_pc          <= r_pc + 32'd4;
                     r_state       <= S_HOLD;
                     r_imem_req    <= 1'b0;
                     r_instr_valid <= 1'b1;
                  end
               end else if (w_take) begin
                  r_pend     <= 1'b1;
                  r_pend_tgt <= w_tgt;
               end
            end
            S_HOLD: begin
               if (w_take) begin
                  r_pc          <= w_tgt;
                  r_state       <= S_REQ;
                  r_imem_req    <= 1'b1;
                  r_instr_valid <= 1'b0;
               end else if (instr_ready) begin
                  r_state       <= S_REQ;
                  r_imem_req    <= 1'b1;
                  r_instr_valid <= 1'b0;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_imem_req    <= 1'b0;
               r_instr_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req      = r_imem_req;
   assign imem_addr     = r_pc;
   assign instr_valid   = r_instr_valid;
   assign instr         = r_instr;
   assign instr_pc      = r_instr_pc;
   assign misalign_trap = r_trap;

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_branch_pc_ctrl                                               |
// | Purpose  : Scoreboard bench for branch_pc_ctrl (fetch-slot reference model)|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_branch_pc_ctrl;

   localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic        is_branch;
   logic        is_jump;
   logic        branch_taken;
   logic [31:0] target_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        misalign_trap;

   int n_tests = 0;
   int n_fail  = 0;
   int ack_mode = 0;   // 0: ack at once, 1: random, 2: withheld

   logic [31:0] fetch_q[$];
   logic [63:0] instr_q[$];

   // Reference model: a fetch "slot" begins when an address is issued and
   // ends when the next address is chosen.
   bit          m_wait_idle;
   bit          m_fetching;
   bit          m_redirected;
   bit          m_trap;
   bit          m_take;
   logic [31:0] m_slot;
   logic [31:0] m_target;
   logic [31:0] m_tgt;

   always #5 clk = ~clk;

   branch_pc_ctrl #(.RESET_PC(C_RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .is_branch      (is_branch),
      .is_jump        (is_jump),
      .branch_taken   (branch_taken),
      .target_addr    (target_addr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .misalign_trap  (misalign_trap)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic start_slot(input logic [31:0] a);
      fetch_q.push_back(a);
      m_slot       = a;
      m_redirected = 1'b0;
      m_fetching   = 1'b1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_q.delete();
         instr_q.delete();
         m_wait_idle  = 1'b1;
         m_fetching   = 1'b0;
         m_redirected = 1'b0;
         m_trap       = 1'b0;
      end else begin
         m_take = redirect_valid && (is_jump || (is_branch && branch_taken));
         m_tgt  = target_addr;
         m_trap = 1'b0;
`ifdef BRANCH_PC_MISALIGN_TRAP_EN
         if (m_take && (m_tgt % 4 != 0)) begin
            m_trap = !m_wait_idle;
            m_take = 1'b0;
         end
`else
         m_tgt = m_tgt - (m_tgt % 4);
`endif
         if (m_wait_idle) begin
            m_wait_idle = 1'b0;
            start_slot(C_RESET_PC);
         end else if (m_fetching) begin
            if (m_take) begin
               m_redirected = 1'b1;
               m_target     = m_tgt;
            end
            if (imem_ack) begin
               if (m_redirected) start_slot(m_target);
               else begin
                  instr_q.push_back({m_slot, imem_rdata});
                  m_fetching = 1'b0;
               end
            end
         end else begin
            if (m_take) start_slot(m_tgt);
            else if (instr_ready) start_slot(m_slot + 32'd4);
         end
      end
   end

   // Monitor
   logic        prev_valid = 1'b0;
   logic [63:0] exp_instr;
   logic [31:0] popped;
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_imem_req", {31'h0, imem_req}, 32'h0);
         check("rst_imem_addr", imem_addr, C_RESET_PC);
         check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
         check("rst_instr", instr, 32'h0);
         check("rst_instr_pc", instr_pc, 32'h0);
         check("rst_trap", {31'h0, misalign_trap}, 32'h0);
         prev_valid = 1'b0;
      end else begin
         check("imem_req", {31'h0, imem_req}, {31'h0, (fetch_q.size() != 0)});
         if (imem_req && fetch_q.size() != 0) begin
            check("imem_addr", imem_addr, fetch_q[0]);
            if (imem_ack) popped = fetch_q.pop_front();
         end
         if (instr_valid && !prev_valid) begin
            if (instr_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL instr_extra: got valid pc %h expected no instruction", instr_pc);
            end else begin
               exp_instr = instr_q.pop_front();
               check("instr_pc", instr_pc, exp_instr[63:32]);
               check("instr", instr, exp_instr[31:0]);
            end
         end
         check("misalign_trap", {31'h0, misalign_trap}, {31'h0, m_trap});
         prev_valid = instr_valid;
      end
   end

   // Memory responder
   always @(posedge clk) begin
      #1;
      imem_rdata = $urandom;
      case (ack_mode)
         0:       imem_ack = imem_req;
         1:       imem_ack = imem_req ? ($urandom_range(0, 2) == 0)
                                      : (!instr_valid && ($urandom_range(0, 3) == 0));
         default: imem_ack = 1'b0;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_redirect(input logic v, input logic b, input logic j,
                               input logic t, input logic [31:0] a);
      redirect_valid = v;
      is_branch      = b;
      is_jump        = j;
      branch_taken   = t;
      target_addr    = a;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 100; i++) begin
         if (instr_valid) return;
         step();
      end
      check("timeout_valid", 32'h0, 32'h1);
   endtask

   task automatic wait_req_addr(input bit any_addr, input logic [31:0] a);
      for (int i = 0; i < 100; i++) begin
         if (imem_req && (any_addr || imem_addr == a)) return;
         step();
      end
      check("timeout_req", imem_addr, a);
   endtask

   initial begin
      rst_n = 1'b0;
      instr_ready = 1'b0;
      set_redirect(0, 0, 0, 0, 32'h0);
      repeat (3) step();
      rst_n = 1'b1;

      instr_ready = 1'b1;
      repeat (10) step();

      // Taken branch while holding an instruction
      instr_ready = 1'b0;
      wait_valid();
      set_redirect(1, 1, 0, 1, 32'h200);
      step();
      set_redirect(0, 0, 0, 0, 32'h0);
      instr_ready = 1'b1;
      repeat (6) step();

      // Not-taken branch
      instr_ready = 1'b0;
      wait_valid();
      set_redirect(1, 1, 0, 0, 32'h200);
      instr_ready = 1'b1;
      step();
      set_redirect(0, 0, 0, 0, 32'h0);
      repeat (6) step();

      // Redirect while the fetch is stalled
      ack_mode = 2;
      wait_req_addr(1'b1, 32'h0);
      set_redirect(1, 0, 1, 0, 32'h300);
      step();
      set_redirect(0, 0, 0, 0, 32'h0);
      repeat (2) step();
      ack_mode = 0;
      repeat (6) step();

      // Misaligned target
      instr_ready = 1'b0;
      wait_valid();
      set_redirect(1, 0, 1, 0, 32'h202);
      step();
      set_redirect(0, 0, 0, 0, 32'h0);
      instr_ready = 1'b1;
      repeat (6) step();

      // Wrap from the top of the address space, then reset during REQ
      instr_ready = 1'b0;
      wait_valid();
      set_redirect(1, 1, 1, 0, 32'hFFFF_FFFC);
      step();
      set_redirect(0, 0, 0, 0, 32'h0);
      instr_ready = 1'b1;
      wait_req_addr(1'b0, 32'h0);
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (6) step();

      // Random traffic
      ack_mode = 1;
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         case ($urandom_range(0, 3))
            0:       a = 32'hFFFF_FFFC;
            1:       a = $urandom;
            2:       a = $urandom & 32'hFFFF_FFFC;
            default: a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         endcase
         instr_ready = 1'($urandom_range(0, 1));
         set_redirect(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
         if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
         else rst_n = 1'b1;
         step();
      end
      rst_n = 1'b1;

      set_redirect(0, 0, 0, 0, 32'h0);
      ack_mode = 0;
      instr_ready = 1'b1;
      repeat (10) step();
      @(negedge clk);
      #1;
      check("drain_instr_q", 32'(instr_q.size()), 32'h0);
      check("drain_fetch_q", {31'h0, (fetch_q.size() > 1)}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
